irq_nest_ctrl: RTL and testbench
================================

Name: irq_nest_ctrl

Overview:
- Parametrised nested-interrupt controller for the single-cycle MIPS datapath. Sits beside the PC-select logic.
- Latches interrupt requests and picks the highest-priority eligible level.
- Saves the resume PC on an internal hardware stack and issues a one-cycle PC redirect to the level's vector.
- On the handler's return instruction, pops the stack and redirects back.
- Generalises the fixed three-level scheme to NUM_IRQ levels, adds per-level masking, pending latches and error reporting.

Parameters:
NUM_IRQ, 3, number of interrupt levels; index NUM_IRQ-1 is highest priority
PC_W, 32, program-counter width
VEC_BASE, 32'h00000038, vector address of level 0
VEC_STRIDE, 32'h00000038, address distance between consecutive level vectors
DEPTH_W, 2, width of depth output; must satisfy 2^DEPTH_W > NUM_IRQ

Ports:
clk  in  1  system clock, all state updates on rising edge
clr  in  1  asynchronous, active-low reset
en  in  1  pipeline advance; no decision is taken when 0
irq_req  in  NUM_IRQ  level request lines, one per level
irq_mask  in  NUM_IRQ  1 = level blocked from entry; pending bit is kept
ret_pc  in  PC_W  address at which the interrupted stream resumes
eret  in  1  return-from-interrupt decoded this cycle
redirect_valid  out  1  one-cycle pulse: PC mux must take redirect_pc
redirect_pc  out  PC_W  target address for redirect
running  out  NUM_IRQ  levels currently entered, not yet returned
pending  out  NUM_IRQ  latched requests not yet serviced
cur_level  out  DEPTH_W  index of innermost running level; 0 when idle
depth  out  DEPTH_W  number of stack entries
ack  out  NUM_IRQ  one-cycle pulse on the level being entered
eret_err  out  1  sticky: eret received while depth==0

Behaviour:
- Reset (clr=0, asynchronous) values:
  - redirect_valid=0, redirect_pc=0, ack=0
  - running=0, pending=0, depth=0, cur_level=0, eret_err=0
  - stack contents=0, edge-detect history=0
- Pending capture:
  - A rising edge of irq_req[i] (sampled history 0, current 1) sets pending[i] every cycle, regardless of en or mask.
  - pending[i] clears only in the cycle level i is entered.
- Eligibility, level i: pending[i] & ~irq_mask[i] & ~running[i], and i > cur_level (or depth==0).
  - Winner is the highest eligible index.
  - A lower or equal level never preempts. It stays pending until outer levels return.
- Decision is taken on the rising clk edge when en=1. Outputs are registered, so the redirect appears the cycle after the triggering inputs.
  - ERET (eret=1, depth>0):
    - pop top entry, redirect_pc=popped value, redirect_valid=1
    - clear running[cur_level], depth-1
    - cur_level = new top level, or 0 if the stack is empty
  - ERET with depth==0: no redirect, eret_err set (sticky until reset), state unchanged.
  - ENTRY (no eret, winner w exists):
    - push {ret_pc, w}, depth+1, running[w]=1, cur_level=w
    - pending[w]=0, ack[w]=1
    - redirect_pc = VEC_BASE + w*VEC_STRIDE, truncated to PC_W, redirect_valid=1
  - Otherwise: redirect_valid=0, ack=0.
- Simultaneous eret and eligible request: the eret wins that cycle. The request stays pending and is re-evaluated next en cycle against the popped state, which allows back-to-back entry.
- en=0: no push/pop/redirect; pending capture continues; redirect_valid and ack are forced 0.
- Stack depth is NUM_IRQ. Each level appears at most once, so overflow is structurally impossible; no overflow logic is required beyond an assertion.
- Stack entries hold PC_W bits plus level index. Only the top entry is read.
- Reset mid-handler discards all nesting state immediately; no redirect is issued.

Test Plan:
- Single entry/return: ret_pc=0x100, pulse irq_req[0], en=1.
  - Next cycle: redirect_pc=0x38, ack[0]=1, depth=1, running=001.
  - Then eret: redirect_pc=0x100, depth=0, running=000.
- Nesting 0→2→1: enter L0 (ret 0x100), then L2 (ret 0x40), then raise L1 inside L2.
  - L1 stays pending, no redirect.
  - eret from L2 → redirect 0x40. Next cycle L1 entered: redirect 0x70, push ret_pc.
  - Two erets unwind to the L1 return address, then 0x100.
- Mask: irq_mask[1]=1, pulse irq_req[1] → pending[1]=1, no redirect. Clear mask → entry at 0x70 next en cycle.
- Simultaneous eret and irq_req[2] in L0 (saved 0x100): first cycle redirect 0x100 with depth 0; next cycle redirect 0xA8 with ack[2]=1.
- Stray eret at depth 0 → no redirect_valid, eret_err=1 and held. en=0 with pulse on irq_req[0] → pending[0]=1, no ack until en=1.
- Async reset asserted mid-L2 (depth=2) between clock edges → all outputs 0 immediately. After release, the old return address is never redirected to.

Source files
------------

// File: rtl/irq_nest_ctrl.sv
// irq_nest_ctrl: nested interrupt controller for the single-cycle MIPS datapath.
// Latches request edges, selects the highest eligible level, and saves the resume
// PC on a small hardware stack. It issues one-cycle PC redirects on entry and on
// return from interrupt.
//
// Output handshake: redirect_valid is a single-cycle pulse and has no ready.
// The PC mux must take redirect_pc in the cycle redirect_valid is high.
// Between pulses, redirect_pc keeps the last target and carries no meaning.
// ack is a one-hot pulse that is asserted in the same cycle as an entry redirect.
module irq_nest_ctrl #(
  parameter int          NUM_IRQ    = 3,
  parameter int          PC_W       = 32,
  parameter logic [31:0] VEC_BASE   = 32'h00000038,
  parameter logic [31:0] VEC_STRIDE = 32'h00000038,
  parameter int          DEPTH_W    = 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic [PC_W-1:0]    ret_pc,
  input  logic               eret,
  output logic               redirect_valid,
  output logic [PC_W-1:0]    redirect_pc,
  output logic [NUM_IRQ-1:0] running,
  output logic [NUM_IRQ-1:0] pending,
  output logic [DEPTH_W-1:0] cur_level,
  output logic [DEPTH_W-1:0] depth,
  output logic [NUM_IRQ-1:0] ack,
  output logic               eret_err
);

  // Architectural state
  logic [NUM_IRQ-1:0] irq_hist_q;
  logic [NUM_IRQ-1:0] pending_q,  pending_d;
  logic [NUM_IRQ-1:0] running_q,  running_d;
  logic [DEPTH_W-1:0] depth_q,    depth_d;
  logic [DEPTH_W-1:0] cur_level_q, cur_level_d;
  logic               eret_err_q, eret_err_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0]    redirect_pc_q,    redirect_pc_d;
  logic [NUM_IRQ-1:0] ack_q,      ack_d;

  // Return stack: one slot per level. Each level is entered at most once,
  // so the stack can never hold more than NUM_IRQ entries.
  logic [PC_W-1:0]    stack_pc_q  [NUM_IRQ];
  logic [DEPTH_W-1:0] stack_lvl_q [NUM_IRQ];

  // Decision signals
  logic [NUM_IRQ-1:0] rise_c;
  logic [NUM_IRQ-1:0] pend_eff_c;
  logic [NUM_IRQ-1:0] elig_c;
  logic               any_elig_c;
  logic [DEPTH_W-1:0] win_c;
  logic [PC_W-1:0]    vec_c;
  logic [PC_W-1:0]    top_pc_c;
  logic [DEPTH_W-1:0] next_top_lvl_c;
  logic               do_pop_c;
  logic               do_push_c;
  logic               stray_eret_c;

  // Find eligible levels. A rising edge in this cycle counts immediately, so
  // a request can be entered in the same cycle as its edge.
  always_comb begin
    rise_c     = irq_req & ~irq_hist_q;
    pend_eff_c = pending_q | rise_c;
    elig_c     = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      elig_c[i] = pend_eff_c[i] & ~irq_mask[i] & ~running_q[i] &
                  ((depth_q == '0) || (DEPTH_W'(i) > cur_level_q));
    end
  end

  // Select the highest eligible index and compute its vector address.
  always_comb begin
    any_elig_c = 1'b0;
    win_c      = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (elig_c[i]) begin
        any_elig_c = 1'b1;
        win_c      = DEPTH_W'(i);
      end
    end
    vec_c = PC_W'(VEC_BASE) + PC_W'(win_c) * PC_W'(VEC_STRIDE);
  end

  // Read the top of the stack, and the level that becomes the top after a pop.
  always_comb begin
    top_pc_c       = '0;
    next_top_lvl_c = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (depth_q == DEPTH_W'(i + 1)) top_pc_c       = stack_pc_q[i];
      if (depth_q == DEPTH_W'(i + 2)) next_top_lvl_c = stack_lvl_q[i];
    end
  end

  // Classify the cycle. If eret and an entry arrive together, the eret wins.
  always_comb begin
    do_pop_c     = en & eret & (depth_q != '0);
    stray_eret_c = en & eret & (depth_q == '0);
    do_push_c    = en & ~eret & any_elig_c;
  end

  // Compute the next state for nesting bookkeeping and the registered outputs.
  always_comb begin
    pending_d        = pend_eff_c;
    running_d        = running_q;
    depth_d          = depth_q;
    cur_level_d      = cur_level_q;
    eret_err_d       = eret_err_q | stray_eret_c;
    redirect_valid_d = do_pop_c | do_push_c;
    redirect_pc_d    = redirect_pc_q;
    ack_d            = '0;
    if (do_pop_c) begin
      redirect_pc_d = top_pc_c;
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (cur_level_q == DEPTH_W'(i)) running_d[i] = 1'b0;
      end
      depth_d     = depth_q - DEPTH_W'(1);
      cur_level_d = next_top_lvl_c;
    end else if (do_push_c) begin
      redirect_pc_d = vec_c;
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (win_c == DEPTH_W'(i)) begin
          running_d[i] = 1'b1;
          pending_d[i] = 1'b0;
          ack_d[i]     = 1'b1;
        end
      end
      depth_d     = depth_q + DEPTH_W'(1);
      cur_level_d = win_c;
    end
  end

  // Register the control state. Reset drops all nesting state at once.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      irq_hist_q       <= '0;
      pending_q        <= '0;
      running_q        <= '0;
      depth_q          <= '0;
      cur_level_q      <= '0;
      eret_err_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      ack_q            <= '0;
    end else begin
      irq_hist_q       <= irq_req;
      pending_q        <= pending_d;
      running_q        <= running_d;
      depth_q          <= depth_d;
      cur_level_q      <= cur_level_d;
      eret_err_q       <= eret_err_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      ack_q            <= ack_d;
    end
  end

  // Stack storage. The only write is a push into the slot at the current depth.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        stack_pc_q[i]  <= '0;
        stack_lvl_q[i] <= '0;
      end
    end else if (do_push_c) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (depth_q == DEPTH_W'(i)) begin
          stack_pc_q[i]  <= ret_pc;
          stack_lvl_q[i] <= win_c;
        end
      end
    end
  end

  // A push must always find a free slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (!clr)
    do_push_c |-> (int'(depth_q) < NUM_IRQ));

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign running        = running_q;
  assign pending        = pending_q;
  assign cur_level      = cur_level_q;
  assign depth          = depth_q;
  assign ack            = ack_q;
  assign eret_err       = eret_err_q;

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// tb_irq_nest_ctrl: directed scenarios for the nested interrupt controller.
// Each expected redirect is queued when its stimulus is driven. The monitor
// pops one entry whenever redirect_valid appears. Static state is checked
// directly at negedges.
module tb_irq_nest_ctrl;

  localparam int NUM_IRQ = 3;
  localparam int PC_W    = 32;
  localparam int DEPTH_W = 2;
  localparam int W       = PC_W + NUM_IRQ + DEPTH_W + NUM_IRQ;

  logic               clk;
  logic               clr;
  logic               en;
  logic [NUM_IRQ-1:0] irq_req;
  logic [NUM_IRQ-1:0] irq_mask;
  logic [PC_W-1:0]    ret_pc;
  logic               eret;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic [NUM_IRQ-1:0] running;
  logic [NUM_IRQ-1:0] pending;
  logic [DEPTH_W-1:0] cur_level;
  logic [DEPTH_W-1:0] depth;
  logic [NUM_IRQ-1:0] ack;
  logic               eret_err;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  irq_nest_ctrl #(
    .NUM_IRQ(NUM_IRQ), .PC_W(PC_W), .VEC_BASE(32'h38), .VEC_STRIDE(32'h38), .DEPTH_W(DEPTH_W)
  ) dut (
    .clk(clk), .clr(clr), .en(en), .irq_req(irq_req), .irq_mask(irq_mask),
    .ret_pc(ret_pc), .eret(eret), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .running(running), .pending(pending),
    .cur_level(cur_level), .depth(depth), .ack(ack), .eret_err(eret_err)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard helpers
  task automatic push_exp(input logic [PC_W-1:0] pc, input logic [NUM_IRQ-1:0] a,
                          input logic [DEPTH_W-1:0] d, input logic [NUM_IRQ-1:0] r);
    exp_q.push_back({pc, a, d, r});
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Driver: apply one cycle of inputs at a negedge and return at the next negedge
  task automatic drive(input logic e, input logic [NUM_IRQ-1:0] req, input logic [NUM_IRQ-1:0] msk,
                       input logic [PC_W-1:0] rpc, input logic er);
    en       = e;
    irq_req  = req;
    irq_mask = msk;
    ret_pc   = rpc;
    eret     = er;
    @(negedge clk);
  endtask

  // Monitor: compare each redirect pulse with the oldest expectation
  always @(posedge clk) begin : monitor
    logic [W-1:0] got;
    logic [W-1:0] want;
    #1;
    if (redirect_valid === 1'b1) begin
      got = {redirect_pc, ack, depth, running};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_redirect actual pc=%h ack=%b depth=%0d run=%b required=none",
                 redirect_pc, ack, depth, running);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL redirect actual pc=%h ack=%b depth=%0d run=%b required pc=%h ack=%b depth=%0d run=%b",
                   got[W-1 -: PC_W], got[7:5], got[4:3], got[2:0],
                   want[W-1 -: PC_W], want[7:5], want[4:3], want[2:0]);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    clr = 1'b0; en = 1'b0; irq_req = '0; irq_mask = '0; ret_pc = '0; eret = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_redirect_valid", 64'(redirect_valid), 0);
    check("rst_redirect_pc", 64'(redirect_pc), 0);
    check("rst_running", 64'(running), 0);
    check("rst_depth", 64'(depth), 0);
    check("rst_eret_err", 64'(eret_err), 0);
    clr = 1'b1;
    @(negedge clk);

    // Single entry and return
    push_exp(32'h38, 3'b001, 2'd1, 3'b001);
    drive(1, 3'b001, 3'b000, 32'h100, 0);
    check("t1_depth", 64'(depth), 1);
    check("t1_pending", 64'(pending), 0);
    drive(1, 3'b000, 3'b000, 32'h0, 0);
    push_exp(32'h100, 3'b000, 2'd0, 3'b000);
    drive(1, 3'b000, 3'b000, 32'h0, 1);
    drive(1, 3'b000, 3'b000, 32'h0, 0);

    // Nesting 0 -> 2, with L1 blocked until L2 returns
    push_exp(32'h38, 3'b001, 2'd1, 3'b001);
    drive(1, 3'b001, 3'b000, 32'h100, 0);
    drive(1, 3'b000, 3'b000, 32'h0, 0);
    push_exp(32'hA8, 3'b100, 2'd2, 3'b101);
    drive(1, 3'b100, 3'b000, 32'h40, 0);
    check("t2_cur_level_l2", 64'(cur_level), 2);
    drive(1, 3'b010, 3'b000, 32'h200, 0);
    check("t2_l1_pending", 64'(pending), 64'b010);
    drive(1, 3'b000, 3'b000, 32'h200, 0);
    push_exp(32'h40, 3'b000, 2'd1, 3'b001);
    drive(1, 3'b000, 3'b000, 32'h300, 1);
    check("t2_cur_level_after_pop", 64'(cur_level), 0);
    push_exp(32'h70, 3'b010, 2'd2, 3'b011);
    drive(1, 3'b000, 3'b000, 32'h300, 0);
    check("t2_cur_level_l1", 64'(cur_level), 1);
    push_exp(32'h300, 3'b000, 2'd1, 3'b001);
    drive(1, 3'b000, 3'b000, 32'h0, 1);
    push_exp(32'h100, 3'b000, 2'd0, 3'b000);
    drive(1, 3'b000, 3'b000, 32'h0, 1);
    drive(1, 3'b000, 3'b000, 32'h0, 0);

    // Masked request stays pending until the mask is lifted
    drive(1, 3'b010, 3'b010, 32'h0, 0);
    drive(1, 3'b000, 3'b010, 32'h0, 0);
    check("t3_masked_pending", 64'(pending), 64'b010);
    check("t3_masked_depth", 64'(depth), 0);
    push_exp(32'h70, 3'b010, 2'd1, 3'b010);
    drive(1, 3'b000, 3'b000, 32'h500, 0);
    push_exp(32'h500, 3'b000, 2'd0, 3'b000);
    drive(1, 3'b000, 3'b000, 32'h0, 1);

    // An eret and an L2 request arriving together: return first, then entry
    push_exp(32'h38, 3'b001, 2'd1, 3'b001);
    drive(1, 3'b001, 3'b000, 32'h100, 0);
    drive(1, 3'b000, 3'b000, 32'h0, 0);
    push_exp(32'h100, 3'b000, 2'd0, 3'b000);
    drive(1, 3'b100, 3'b000, 32'h0, 1);
    push_exp(32'hA8, 3'b100, 2'd1, 3'b100);
    drive(1, 3'b000, 3'b000, 32'h600, 0);
    push_exp(32'h600, 3'b000, 2'd0, 3'b000);
    drive(1, 3'b000, 3'b000, 32'h0, 1);

    // Stray eret is sticky; en=0 captures pending without entering
    drive(1, 3'b000, 3'b000, 32'h0, 1);
    check("t5_eret_err", 64'(eret_err), 1);
    drive(1, 3'b000, 3'b000, 32'h0, 0);
    check("t5_eret_err_held", 64'(eret_err), 1);
    check("t5_depth", 64'(depth), 0);
    drive(0, 3'b001, 3'b000, 32'h0, 0);
    check("t5_en0_pending", 64'(pending), 64'b001);
    check("t5_en0_ack", 64'(ack), 0);
    drive(0, 3'b000, 3'b000, 32'h0, 0);
    push_exp(32'h38, 3'b001, 2'd1, 3'b001);
    drive(1, 3'b000, 3'b000, 32'h700, 0);
    check("t5_pending_cleared", 64'(pending), 0);
    push_exp(32'h700, 3'b000, 2'd0, 3'b000);
    drive(1, 3'b000, 3'b000, 32'h0, 1);

    // Asynchronous reset while in L2
    push_exp(32'h38, 3'b001, 2'd1, 3'b001);
    drive(1, 3'b001, 3'b000, 32'h100, 0);
    push_exp(32'hA8, 3'b100, 2'd2, 3'b101);
    drive(1, 3'b100, 3'b000, 32'h44, 0);
    irq_req = '0;
    en      = 1'b0;
    #2 clr = 1'b0;
    #1;
    check("arst_redirect_valid", 64'(redirect_valid), 0);
    check("arst_redirect_pc", 64'(redirect_pc), 0);
    check("arst_ack", 64'(ack), 0);
    check("arst_running", 64'(running), 0);
    check("arst_pending", 64'(pending), 0);
    check("arst_depth", 64'(depth), 0);
    check("arst_cur_level", 64'(cur_level), 0);
    check("arst_eret_err", 64'(eret_err), 0);
    @(negedge clk);
    clr = 1'b1;
    drive(1, 3'b000, 3'b000, 32'h0, 1);
    check("post_rst_eret_err", 64'(eret_err), 1);
    push_exp(32'h70, 3'b010, 2'd1, 3'b010);
    drive(1, 3'b010, 3'b000, 32'h800, 0);
    push_exp(32'h800, 3'b000, 2'd0, 3'b000);
    drive(1, 3'b000, 3'b000, 32'h0, 1);
    repeat (3) drive(1, 3'b000, 3'b000, 32'h0, 0);

    check("queue_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
